// File: rtl/if_id_queue_if.sv
// Instruction handshake channel between pipeline stages: a valid/ready pair
// carrying {pc, pc_4, instr}. The master drives the payload and valid; the
// slave returns ready.
interface if_id_queue_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic [31:0] instr;

  modport master (output valid, output pc, output pc_4, output instr, input ready);
  modport slave  (input valid, input pc, input pc_4, input instr, output ready);
endinterface

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction buffer. A small FIFO of {pc, pc_4, instr}
// with no fall-through: an entry is visible at the decode side one cycle
// after it is captured. flush discards everything, taking priority over
// push and pop in the same cycle.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  if_id_queue_if.slave  fetch,
  if_id_queue_if.master dec,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   pc_4_mem  [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake flags depend only on the stored count, so ready never
  // combinationally follows the decode side.
  always_comb begin
    fetch.ready = (count != FULL);
    dec.valid   = (count != '0);
    push        = fetch.valid & fetch.ready;
    pop         = dec.valid & dec.ready;
  end

  // Head entry comes straight from storage; the instruction reads as a NOP
  // whenever nothing valid is held.
  always_comb begin
    dec.pc    = pc_mem[rd_ptr];
    dec.pc_4  = pc_4_mem[rd_ptr];
    dec.instr = dec.valid ? instr_mem[rd_ptr] : 32'h0;
  end

  // Pointer, count and storage update; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        pc_4_mem[i]  <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= fetch.pc;
        pc_4_mem[wr_ptr]  <= fetch.pc_4;
        instr_mem[wr_ptr] <= fetch.instr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for the fetch-to-decode queue: reset, latency, fill/stall,
// streaming, flush, empty pop and asynchronous mid-run reset.
module tb_if_id_queue;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       flush;
  logic [1:0] count;

  int checks   = 0;
  int failures = 0;

  if_id_queue_if fetch_bus ();
  if_id_queue_if dec_bus ();

  if_id_queue #(.DEPTH(2), .AW(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .fetch (fetch_bus),
    .dec   (dec_bus),
    .count (count)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    fetch_bus.valid = v;
    fetch_bus.pc    = pc;
    fetch_bus.pc_4  = pc + 32'd4;
    fetch_bus.instr = instr_of(pc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (count !== 2'd0) begin
      failures++; $display("FAIL reset_count actual=%0d required=0", count);
    end
    checks++;
    if (dec_bus.valid !== 1'b0 || fetch_bus.ready !== 1'b1) begin
      failures++; $display("FAIL reset_flags actual id_valid=%b if_ready=%b required 0/1", dec_bus.valid, fetch_bus.ready);
    end
    checks++;
    if (dec_bus.pc !== 32'h0 || dec_bus.pc_4 !== 32'h0 || dec_bus.instr !== 32'h0) begin
      failures++; $display("FAIL reset_data actual pc=%h pc_4=%h instr=%h required 0", dec_bus.pc, dec_bus.pc_4, dec_bus.instr);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    fetch_bus.valid = 1'b1;
    fetch_bus.pc    = 32'h0000_0010;
    fetch_bus.pc_4  = 32'h0000_0014;
    fetch_bus.instr = 32'h8C08_0004;
    checks++;
    if (dec_bus.valid !== 1'b0 || dec_bus.instr !== 32'h0) begin
      failures++; $display("FAIL latency_no_fallthrough actual id_valid=%b instr=%h required 0/0", dec_bus.valid, dec_bus.instr);
    end
    step();
    fetch_bus.valid = 1'b0;
    checks++;
    if (dec_bus.valid !== 1'b1 || dec_bus.pc !== 32'h10 || dec_bus.pc_4 !== 32'h14 || dec_bus.instr !== 32'h8C08_0004) begin
      failures++; $display("FAIL latency_head actual v=%b pc=%h pc_4=%h instr=%h required 1/10/14/8c080004",
                           dec_bus.valid, dec_bus.pc, dec_bus.pc_4, dec_bus.instr);
    end
    dec_bus.ready = 1'b1;
    step();
    dec_bus.ready = 1'b0;
    checks++;
    if (count !== 2'd0 || dec_bus.instr !== 32'h0) begin
      failures++; $display("FAIL latency_drain actual count=%0d instr=%h required 0/0", count, dec_bus.instr);
    end
  endtask

  task automatic test_fill_stall();
    dec_bus.ready = 1'b0;
    offer(1'b1, 32'h0);
    step();
    offer(1'b1, 32'h4);
    step();
    offer(1'b1, 32'h8);
    checks++;
    if (count !== 2'd2 || fetch_bus.ready !== 1'b0) begin
      failures++; $display("FAIL fill_full actual count=%0d if_ready=%b required 2/0", count, fetch_bus.ready);
    end
    step();
    checks++;
    if (count !== 2'd2 || dec_bus.pc !== 32'h0 || dec_bus.instr !== instr_of(32'h0)) begin
      failures++; $display("FAIL fill_held actual count=%0d head=%h required 2/0", count, dec_bus.pc);
    end
    dec_bus.ready = 1'b1;
    checks++;
    if (fetch_bus.ready !== 1'b0) begin
      failures++; $display("FAIL fill_ready_indep actual if_ready=%b required 0", fetch_bus.ready);
    end
    step();
    checks++;
    if (count !== 2'd1 || dec_bus.pc !== 32'h4 || fetch_bus.ready !== 1'b1) begin
      failures++; $display("FAIL fill_pop1 actual count=%0d head=%h if_ready=%b required 1/4/1", count, dec_bus.pc, fetch_bus.ready);
    end
    step();
    offer(1'b0, 32'h0);
    checks++;
    if (count !== 2'd1 || dec_bus.pc !== 32'h8 || dec_bus.pc_4 !== 32'hC || dec_bus.instr !== instr_of(32'h8)) begin
      failures++; $display("FAIL fill_pop2 actual count=%0d head=%h pc_4=%h required 1/8/c", count, dec_bus.pc, dec_bus.pc_4);
    end
    step();
    dec_bus.ready = 1'b0;
    checks++;
    if (count !== 2'd0 || dec_bus.valid !== 1'b0) begin
      failures++; $display("FAIL fill_drain actual count=%0d id_valid=%b required 0/0", count, dec_bus.valid);
    end
  endtask

  task automatic test_streaming();
    dec_bus.ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      offer(1'b1, 32'(4 * i));
      step();
      checks++;
      if (count !== 2'd1 || dec_bus.pc !== 32'(4 * i) || dec_bus.instr !== instr_of(32'(4 * i))) begin
        failures++; $display("FAIL stream_%0d actual count=%0d head=%h required 1/%h", i, count, dec_bus.pc, 32'(4 * i));
      end
    end
    offer(1'b0, 32'h0);
    step();
    dec_bus.ready = 1'b0;
    checks++;
    if (count !== 2'd0 || dec_bus.valid !== 1'b0) begin
      failures++; $display("FAIL stream_drain actual count=%0d id_valid=%b required 0/0", count, dec_bus.valid);
    end
  endtask

  task automatic test_flush();
    offer(1'b1, 32'h100);
    step();
    offer(1'b1, 32'h104);
    step();
    checks++;
    if (count !== 2'd2) begin
      failures++; $display("FAIL flush_pre actual count=%0d required 2", count);
    end
    flush = 1'b1;
    offer(1'b1, 32'h108);
    dec_bus.ready = 1'b1;
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0);
    dec_bus.ready = 1'b0;
    checks++;
    if (count !== 2'd0 || dec_bus.valid !== 1'b0 || dec_bus.instr !== 32'h0) begin
      failures++; $display("FAIL flush_full actual count=%0d id_valid=%b instr=%h required 0/0/0", count, dec_bus.valid, dec_bus.instr);
    end
    // One stored entry, so if_ready=1 while flushing: the offered push must still be dropped.
    offer(1'b1, 32'h200);
    step();
    flush = 1'b1;
    offer(1'b1, 32'h204);
    checks++;
    if (fetch_bus.ready !== 1'b1) begin
      failures++; $display("FAIL flush_if_ready actual=%b required 1", fetch_bus.ready);
    end
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0);
    checks++;
    if (count !== 2'd0 || dec_bus.valid !== 1'b0 || dut.wr_ptr !== 1'b0 || dut.rd_ptr !== 1'b0) begin
      failures++; $display("FAIL flush_push_dropped actual count=%0d id_valid=%b wr=%b rd=%b required 0/0/0/0",
                           count, dec_bus.valid, dut.wr_ptr, dut.rd_ptr);
    end
  endtask

  task automatic test_empty_pop();
    dec_bus.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== 2'd0 || dut.rd_ptr !== 1'b0 || dut.wr_ptr !== 1'b0) begin
        failures++; $display("FAIL empty_pop_%0d actual count=%0d rd=%b wr=%b required 0/0/0", i, count, dut.rd_ptr, dut.wr_ptr);
      end
    end
    dec_bus.ready = 1'b0;
    offer(1'b1, 32'h300);
    step();
    offer(1'b0, 32'h0);
    checks++;
    if (count !== 2'd1 || dec_bus.pc !== 32'h300) begin
      failures++; $display("FAIL empty_then_push actual count=%0d head=%h required 1/300", count, dec_bus.pc);
    end
  endtask

  task automatic test_async_reset();
    offer(1'b1, 32'h400);
    step();
    offer(1'b0, 32'h0);
    clk_en = 1'b0;
    #7;
    rst = 1'b1;
    #2;
    checks++;
    if (count !== 2'd0 || dec_bus.valid !== 1'b0 || dec_bus.instr !== 32'h0 || fetch_bus.ready !== 1'b1) begin
      failures++; $display("FAIL async_reset actual count=%0d id_valid=%b instr=%h if_ready=%b required 0/0/0/1",
                           count, dec_bus.valid, dec_bus.instr, fetch_bus.ready);
    end
    checks++;
    if (dec_bus.pc !== 32'h0 || dec_bus.pc_4 !== 32'h0) begin
      failures++; $display("FAIL async_reset_storage actual pc=%h pc_4=%h required 0/0", dec_bus.pc, dec_bus.pc_4);
    end
  endtask

  initial begin
    clk_en        = 1'b1;
    rst           = 1'b1;
    flush         = 1'b0;
    dec_bus.ready = 1'b0;
    offer(1'b0, 32'h0);
    test_reset();
    test_latency();
    test_fill_stall();
    test_streaming();
    test_flush();
    test_empty_pop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
